// File: rtl/seq_divider16x8.sv
// Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor.
// One quotient bit per clock, MSB first; start/busy/done handshake.
module seq_divider16x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_reg;
  logic [15:0] d_reg;
  logic [7:0]  v_reg;
  logic [8:0]  r_reg;
  logic [4:0]  cnt_reg;

  logic [8:0]  trial;
  logic [8:0]  diff;
  logic        fits;
  logic [15:0] d_next;
  logic [8:0]  r_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial  = {r_reg[7:0], d_reg[15]};
    diff   = trial - {1'b0, v_reg};
    fits   = (trial >= {1'b0, v_reg});
    d_next = {d_reg[14:0], fits};
    r_next = fits ? diff : trial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      d_reg       <= 16'h0000;
      v_reg       <= 8'h00;
      r_reg       <= 9'h000;
      cnt_reg     <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'h0000;
      remainder   <= 8'h00;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            d_reg   <= dividend;
            v_reg   <= divisor;
            r_reg   <= 9'h000;
            cnt_reg <= 5'd0;
            if (divisor == 8'h00) begin
              state_reg   <= DONE;
              done        <= 1'b1;
              quotient    <= 16'hFFFF;
              remainder   <= 8'h00;
              div_by_zero <= 1'b1;
            end else begin
              state_reg <= CALC;
              busy      <= 1'b1;
            end
          end
        end
        CALC: begin
          d_reg <= d_next;
          r_reg <= r_next;
          if (cnt_reg == 5'd15) begin
            // Results are published on the same edge that enters DONE.
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= d_next;
            remainder   <= r_next[7:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16x8.sv
// Scoreboard bench for seq_divider16x8: the driver queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_divider16x8 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          cyc;
    int          busy_len;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   ncmp = 0;
  int   nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts busy cycles per operation and checks each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    else if (!done) busy_cnt = 0;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", {16'h0, quotient}, {16'h0, e.q});
        chk("remainder", {24'h0, remainder}, {24'h0, e.r});
        chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.z});
        chk("done_cycle", cyc, e.cyc);
        chk("busy_len", busy_cnt, e.busy_len);
        $display("op: q=%04h r=%02h z=%0b at cycle %0d", quotient, remainder, div_by_zero, cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic issue(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er);
    exp_t e;
    e.q        = eq;
    e.r        = er;
    e.z        = (b == 8'h00);
    e.cyc      = cyc + 1 + ((b == 8'h00) ? 0 : 16);
    e.busy_len = (b == 8'h00) ? 0 : 16;
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("timeout_pending", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [7:0]  a8, b8;
    logic [15:0] x;
    rst = 1'b1; start = 1'b0; dividend = 16'h0; divisor = 8'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_quotient", {16'h0, quotient}, 32'd0);
    chk("reset_remainder", {24'h0, remainder}, 32'd0);
    chk("reset_dbz", {31'h0, div_by_zero}, 32'd0);

    // Directed vectors
    issue(16'h03E8, 8'h07, 16'd142, 8'd6);      wait_idle();
    issue(16'hFFFF, 8'h01, 16'hFFFF, 8'h00);    wait_idle();
    issue(16'hFFFF, 8'hFF, 16'h0101, 8'h00);    wait_idle();
    issue(16'h00C8, 8'hFA, 16'h0000, 8'hC8);    wait_idle();
    issue(16'h0005, 8'h00, 16'hFFFF, 8'h00);    wait_idle();
    issue(16'h0005, 8'h02, 16'h0002, 8'h01);    wait_idle();

    // Start pulses and operand churn during CALC must be ignored
    issue(16'h1234, 8'h10, 16'h0123, 8'h04);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'h0FFF; divisor = 8'h03;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dividend = ~dividend; divisor = 8'(i);
    end
    wait_idle();

    // Start held high: one result every 18 cycles
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.q = 16'd142; e.r = 8'd6; e.z = 1'b0;
      e.cyc = k + 1 + 18 * i + 16; e.busy_len = 16;
      sb.push_back(e);
    end
    start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
    while (cyc < k + 37) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during CALC iteration 8
    issue(16'h03E8, 8'h07, 16'd142, 8'd6);
    void'(sb.pop_back());
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_quotient", {16'h0, quotient}, 32'd0);
    chk("midrst_remainder", {24'h0, remainder}, 32'd0);
    chk("midrst_dbz", {31'h0, div_by_zero}, 32'd0);
    repeat (25) @(negedge clk);
    chk("midrst_still_idle", {31'h0, busy}, 32'd0);
    issue(16'd255, 8'd16, 16'd15, 8'd15);       wait_idle();

    // Round-trip of multiplier products
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(1, 255));
      issue(16'(a8) * 16'(b8), b8, 16'(a8), 8'h00);
      wait_idle();
    end

    // Random operands, reference by integer divide
    for (int i = 0; i < 2000; i++) begin
      x  = 16'($urandom);
      b8 = 8'($urandom_range(0, 255));
      if (b8 == 8'h00) issue(x, b8, 16'hFFFF, 8'h00);
      else issue(x, b8, x / 16'(b8), 8'(x % 16'(b8)));
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
